// File: rtl/pmm_pkg.sv
// Shared definitions for the parallel matrix multiplier.
//   DATA_W   : element width (two's-complement, arithmetic wraps modulo 2^DATA_W)
//   state_e  : controller states IDLE -> RUN -> DONE
//   idx_w    : row/column index width for an n x n matrix
//   mac_wrap : one multiply-accumulate step truncated to DATA_W bits
package pmm_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  // The low DATA_W bits of a product do not depend on signedness, so the
  // signed multiply gives the same bits an unsigned one would.
  function automatic logic [DATA_W-1:0] mac_wrap(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] prod;
    prod = DATA_W'($signed(a) * $signed(b));
    return acc + prod;
  endfunction

endpackage

// File: rtl/pmm_mac_lane.sv
// One multiply-accumulate lane.
//   clk, rst : clock, asynchronous active-low reset (clears the accumulator)
//   clr      : clear the accumulator on this edge (priority over en)
//   en       : add a*b to the accumulator
//   a, b     : operands for this cycle's term
//   acc      : running total including this cycle's term when en=1, so the
//              owner can store a finished dot product on its last term
//              without waiting an extra cycle
module pmm_mac_lane
  import pmm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  assign acc = en ? mac_wrap(acc_q, a, b) : acc_q;

  always_comb begin
    acc_d = clr ? '0 : acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/parallel_matrix_mult.sv
// C = A x B for n x n matrices of 32-bit integers using m parallel MAC lanes.
// A and B are constant ROMs built from A_INIT / B_INIT (element x = i*n+j
// occupies bits [x*32 +: 32], row-major).
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset (FSM, counters, accumulators)
//   start  : begin a multiplication (ignored while running)
//   z_i    : row index of the result element to read
//   z_j    : column index of the result element to read
//   z_out  : C[z_i][z_j], combinational; 0 for out-of-range indices
//   done   : high while C is complete and valid
module parallel_matrix_mult
  import pmm_pkg::*;
#(
  parameter int                        n      = 4,
  parameter int                        m      = 2,
  parameter logic [n*n*DATA_W-1:0]     A_INIT = '0,
  parameter logic [n*n*DATA_W-1:0]     B_INIT = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [$clog2(n)-1:0]    z_i,
  input  logic [$clog2(n)-1:0]    z_j,
  output logic [DATA_W-1:0]       z_out,
  output logic                    done
);

  localparam int NN    = n * n;
  localparam int N_LEN = idx_w(n);
  localparam int AW    = $clog2(NN);
  // e can reach NN-1+m before the end-of-run compare.
  localparam int EW    = $clog2(NN + m + 1);

  logic [DATA_W-1:0] rom_a [NN];
  logic [DATA_W-1:0] rom_b [NN];
  logic [DATA_W-1:0] mem_q [NN];

  for (genvar x = 0; x < NN; x++) begin : g_rom
    assign rom_a[x] = A_INIT[x*DATA_W +: DATA_W];
    assign rom_b[x] = B_INIT[x*DATA_W +: DATA_W];
  end

  state_e           state_q, state_d;
  logic [N_LEN-1:0] k_q, k_d;
  logic [EW-1:0]    e_q, e_d;
  logic             done_q, done_d;
  logic             last_k, grp_last;
  logic             run, clr, wr;

  assign last_k   = (k_q == N_LEN'(n - 1));
  assign grp_last = ((e_q + EW'(m)) >= EW'(NN));

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_k && grp_last) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. done is registered one cycle behind entry to DONE and
  // drops on the same edge that samples a restart.
  always_comb begin
    run    = (state_q == RUN);
    clr    = !run || last_k;
    wr     = run && last_k;
    done_d = (state_q == DONE) && !start;
  end

  // Term counter k and element base e; both sit at 0 outside RUN so every
  // run starts from the first element.
  always_comb begin
    k_d = '0;
    e_d = '0;
    if (run) begin
      k_d = last_k ? '0 : k_q + N_LEN'(1);
      e_d = last_k ? e_q + EW'(m) : e_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q    <= '0;
      e_q    <= '0;
      done_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      e_q    <= e_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;

  logic [DATA_W-1:0] lane_acc  [m];
  logic [AW-1:0]     lane_addr [m];
  logic              lane_act  [m];

  for (genvar l = 0; l < m; l++) begin : g_lane
    logic [EW-1:0]     elem;
    logic [N_LEN-1:0]  ri, cj;
    logic [AW-1:0]     ai, bi;
    logic [DATA_W-1:0] a, b;
    logic              en;

    assign elem          = e_q + EW'(l);
    assign lane_act[l]   = (elem < EW'(NN));
    assign ri            = N_LEN'(elem / EW'(n));
    assign cj            = N_LEN'(elem % EW'(n));
    assign lane_addr[l]  = AW'(elem);
    assign ai            = AW'(ri) * AW'(n) + AW'(k_q);
    assign bi            = AW'(k_q) * AW'(n) + AW'(cj);
    // Lanes past the last element are gated so they never index the ROMs.
    assign a             = lane_act[l] ? rom_a[ai] : '0;
    assign b             = lane_act[l] ? rom_b[bi] : '0;
    assign en            = run && lane_act[l];

    pmm_mac_lane u_mac (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (en),
      .a   (a),
      .b   (b),
      .acc (lane_acc[l])
    );
  end

  // Result RAM: m write ports, not reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int l = 0; l < m; l++) begin
        if (lane_act[l]) begin
          mem_q[lane_addr[l]] <= lane_acc[l];
        end
      end
    end
  end

  logic [AW-1:0] rd_addr;
  assign rd_addr = AW'(z_i) * AW'(n) + AW'(z_j);

  if ((1 << N_LEN) == n) begin : g_rd_pow2
    assign z_out = mem_q[rd_addr];
  end else begin : g_rd_guard
    assign z_out = (z_i < N_LEN'(n) && z_j < N_LEN'(n)) ? mem_q[rd_addr] : '0;
  end

endmodule

// File: tb/tb_parallel_matrix_mult.sv
// Directed bench for parallel_matrix_mult: three instances
//   dut0: n=2 m=2, A=[[1,2],[3,4]] B=[[5,6],[7,8]]
//   dut1: n=4 m=2, A=identity B=1..16
//   dut2: n=2 m=1, wrap-around operands
module tb_parallel_matrix_mult;
  import pmm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n;
  logic [2:0]  start;
  logic [2:0]  done;
  logic [31:0] zo0, zo1, zo2;
  logic [0:0]  zi0, zj0, zi2, zj2;
  logic [1:0]  zi1, zj1;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] A0 = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] B0 = {32'd8, 32'd7, 32'd6, 32'd5};
  localparam logic [511:0] A1 = {32'd1, 32'd0, 32'd0, 32'd0,
                                 32'd0, 32'd1, 32'd0, 32'd0,
                                 32'd0, 32'd0, 32'd1, 32'd0,
                                 32'd0, 32'd0, 32'd0, 32'd1};
  localparam logic [511:0] B1 = {32'd16, 32'd15, 32'd14, 32'd13,
                                 32'd12, 32'd11, 32'd10, 32'd9,
                                 32'd8,  32'd7,  32'd6,  32'd5,
                                 32'd4,  32'd3,  32'd2,  32'd1};
  localparam logic [127:0] A2 = {32'd1, 32'd0, 32'd0, 32'h0001_0000};
  localparam logic [127:0] B2 = {32'hFFFF_FFFF, 32'd0, 32'd0, 32'h0001_0000};

  parallel_matrix_mult #(.n(2), .m(2), .A_INIT(A0), .B_INIT(B0)) dut0 (
    .clk(clk), .rst(rst_n[0]), .start(start[0]), .z_i(zi0), .z_j(zj0),
    .z_out(zo0), .done(done[0]));

  parallel_matrix_mult #(.n(4), .m(2), .A_INIT(A1), .B_INIT(B1)) dut1 (
    .clk(clk), .rst(rst_n[1]), .start(start[1]), .z_i(zi1), .z_j(zj1),
    .z_out(zo1), .done(done[1]));

  parallel_matrix_mult #(.n(2), .m(1), .A_INIT(A2), .B_INIT(B2)) dut2 (
    .clk(clk), .rst(rst_n[2]), .start(start[2]), .z_i(zi2), .z_j(zj2),
    .z_out(zo2), .done(done[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] s, input int i, input int j, output logic [31:0] v);
    case (s)
      2'd0:    begin zi0 = 1'(i); zj0 = 1'(j); end
      2'd1:    begin zi1 = 2'(i); zj1 = 2'(j); end
      default: begin zi2 = 1'(i); zj2 = 1'(j); end
    endcase
    #1;
    case (s)
      2'd0:    v = zo0;
      2'd1:    v = zo1;
      default: v = zo2;
    endcase
  endtask

  // Pulses start for one cycle, then counts edges until done (bounded).
  // d0 is done just after the sampling edge; pulse_at re-raises start for
  // the cycle after that many edges (-1 for none).
  task automatic run(input logic [1:0] s, input int pulse_at, output int lat, output logic d0);
    @(negedge clk);
    start[s] = 1'b1;
    @(posedge clk);
    #1;
    start[s] = 1'b0;
    d0  = done[s];
    lat = 0;
    while (done[s] !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      start[s] = (lat == pulse_at);
    end
    start[s] = 1'b0;
  endtask

  int          lat;
  logic        d0;
  logic        hi;
  logic [31:0] v;
  logic [31:0] c0 [4];

  initial begin
    c0[0] = 32'd19; c0[1] = 32'd22; c0[2] = 32'd43; c0[3] = 32'd50;
    rst_n = 3'b000;
    start = 3'b000;
    zi0 = '0; zj0 = '0; zi1 = '0; zj1 = '0; zi2 = '0; zj2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done0", 32'(done[0]), 32'd0);
    check("reset_done1", 32'(done[1]), 32'd0);
    check("reset_done2", 32'(done[2]), 32'd0);
    @(negedge clk);
    rst_n = 3'b111;

    // Case 1: 2x2, two lanes
    run(2'd0, -1, lat, d0);
    check("c1_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        rd(2'd0, i, j, v);
        check($sformatf("c1_C%0d%0d", i, j), v, c0[i*2+j]);
      end

    // Case 4: restart from DONE with a mid-run start pulse
    run(2'd0, 2, lat, d0);
    check("c4_done_drop", 32'(d0), 32'd0);
    check("c4_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        rd(2'd0, i, j, v);
        check($sformatf("c4_C%0d%0d", i, j), v, c0[i*2+j]);
      end

    // Case 2: identity x (1..16)
    run(2'd1, -1, lat, d0);
    check("c2_latency", 32'(lat), 32'd33);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        rd(2'd1, i, j, v);
        check($sformatf("c2_C%0d%0d", i, j), v, 32'(i*4 + j + 1));
      end

    // Case 5: reset pulse mid-run aborts, then a clean rerun
    @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    hi = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done[1] !== 1'b0) hi = 1'b1;
    end
    check("c5_abort_no_done", 32'(hi), 32'd0);
    run(2'd1, -1, lat, d0);
    check("c5_latency", 32'(lat), 32'd33);
    rd(2'd1, 0, 0, v);  check("c5_C00", v, 32'd1);
    rd(2'd1, 2, 1, v);  check("c5_C21", v, 32'd10);
    rd(2'd1, 3, 3, v);  check("c5_C33", v, 32'd16);

    // Case 3: wrap-around arithmetic, single lane
    run(2'd2, -1, lat, d0);
    check("c3_latency", 32'(lat), 32'd9);
    rd(2'd2, 0, 0, v);  check("c3_C00", v, 32'h0000_0000);
    rd(2'd2, 0, 1, v);  check("c3_C01", v, 32'h0000_0000);
    rd(2'd2, 1, 0, v);  check("c3_C10", v, 32'h0000_0000);
    rd(2'd2, 1, 1, v);  check("c3_C11", v, 32'hFFFF_FFFF);

    // Case 6: reset held low drops done immediately and blocks start
    @(negedge clk);
    check("c6_done_before", 32'(done[2]), 32'd1);
    rst_n[2] = 1'b0;
    #1;
    check("c6_async_clear", 32'(done[2]), 32'd0);
    hi = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start[2] = (c % 10 == 0);
      @(posedge clk);
      #1;
      if (done[2] !== 1'b0) hi = 1'b1;
    end
    start[2] = 1'b0;
    check("c6_held_no_done", 32'(hi), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
